// File: rtl/alu_shift_unit_if.sv
// alu_shift_unit_if -- request/response bundle for alu_shift_unit.
//   Request side : in_valid/in_ready handshake plus operands (src1, src2),
//                  ALU controls (invertA, invertB, operation) and shift
//                  controls (isShift, leftRight, arith, shamt).
//   Response side: out_valid/out_ready handshake plus result, zero, overflow.
// The master modport is for the requester; the slave modport is for the unit.
interface alu_shift_unit_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             invertA;
    logic             invertB;
    logic [1:0]       operation;
    logic             isShift;
    logic             leftRight;
    logic             arith;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;

    modport master (
        output in_valid, src1, src2, invertA, invertB, operation,
               isShift, leftRight, arith, shamt, out_ready,
        input  in_ready, out_valid, result, zero, overflow
    );

    modport slave (
        input  in_valid, src1, src2, invertA, invertB, operation,
               isShift, leftRight, arith, shamt, out_ready,
        output in_ready, out_valid, result, zero, overflow
    );
endinterface

// File: rtl/alu_shift_unit.sv
// alu_shift_unit -- single-issue ALU (AND/OR/ADD/SLT with operand inversion)
// and iterative one-bit-per-cycle shifter behind a valid/ready handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_shift_unit_if.slave (request fields, result, zero, overflow,
//           in_valid/in_ready and out_valid/out_ready handshakes)
// ALU requests complete on the accept edge; shift requests take shamt edges.
// The result register doubles as the shift working register, so the result
// is only meaningful while out_valid is high.
module alu_shift_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_shift_unit_if.slave bus
);
    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_overflow;
    logic [SHW-1:0]   r_cnt;
    logic             r_left;
    logic             r_arith;

    logic             w_accept;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_sum;
    logic             w_add_ovf;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_ovf;
    logic [WIDTH-1:0] w_shift_next;

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.overflow  = r_overflow;

    assign w_accept = bus.in_valid && (r_state == IDLE);

    // Subtraction is a + ~b + 1: the carry-in follows invertB.
    assign w_a       = bus.invertA ? ~bus.src1 : bus.src1;
    assign w_b       = bus.invertB ? ~bus.src2 : bus.src2;
    assign w_sum     = w_a + w_b + {{(WIDTH-1){1'b0}}, bus.invertB};
    assign w_add_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);

    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        case (bus.operation)
            2'b00: w_alu_res = w_a & w_b;
            2'b01: w_alu_res = w_a | w_b;
            2'b10: begin
                w_alu_res = w_sum;
                w_alu_ovf = w_add_ovf;
            end
            default: begin
                // Signed less-than: sign of the true (overflow-corrected) difference.
                w_alu_res[0] = w_sum[WIDTH-1] ^ w_add_ovf;
            end
        endcase
    end

    // One-bit step of the working register; arithmetic right shifts replicate the MSB.
    assign w_shift_next = r_left ? {r_result[WIDTH-2:0], 1'b0}
                                 : {r_arith & r_result[WIDTH-1], r_result[WIDTH-1:1]};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.isShift && (bus.shamt != '0)) w_state_next = SHIFT;
                    else                                  w_state_next = DONE;
                end
            end
            SHIFT: begin
                if (r_cnt == CNT_ONE) w_state_next = DONE;
            end
            DONE: begin
                if (bus.out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_overflow <= 1'b0;
            r_cnt      <= '0;
            r_left     <= 1'b0;
            r_arith    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (bus.isShift) begin
                            r_result   <= bus.src1;
                            r_overflow <= 1'b0;
                            r_cnt      <= bus.shamt;
                            r_left     <= bus.leftRight;
                            r_arith    <= bus.arith;
                            // A zero-length shift completes now; otherwise zero is set on the last step.
                            r_zero     <= (bus.shamt == '0) && (bus.src1 == '0);
                        end else begin
                            r_result   <= w_alu_res;
                            r_overflow <= w_alu_ovf;
                            r_zero     <= (w_alu_res == '0);
                        end
                    end
                end
                SHIFT: begin
                    r_result <= w_shift_next;
                    r_cnt    <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) r_zero <= (w_shift_next == '0);
                end
                default: ;
            endcase
        end
    end
endmodule
